fifo_unpacker: RTL and testbench

Downstream consumer of the synchronous `fifo`. It pops wide words from the FIFO's first-word-fall-through read port and re-emits each word as a sequence of narrow samples on a valid/ready stream. The samples feed the FIR datapath. Each word splits into `RATIO = IN_WIDTH/OUT_WIDTH` slices; the block pops the next word in the same cycle the last slice is accepted, so throughput is one slice per cycle with no bubble.

---
 rtl/fifo_unpacker.sv | 121 ++++++++++++
 tb/tb_fifo_unpacker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops wide words from a first-word-fall-through FIFO and
// re-emits each one as RATIO narrow samples on a valid/ready stream.
// The next word is popped in the same cycle the last slice is accepted,
// so a continuously ready consumer sees one slice per cycle with no gap.
module fifo_unpacker #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [IN_WIDTH-1:0]  data_in,
   output logic                 r_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   // IDLE: hold register holds nothing to send; UNPACK: slices pending.
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_UNPACK = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [IN_WIDTH-1:0]   hold_q, hold_d;
   logic [IDX_W-1:0]      idx_q, idx_d;

   logic                  busy_s;
   logic                  fire_s;
   logic                  last_fire_s;
   logic                  pop_s;
   logic [IDX_W-1:0]      sel_s;
   logic [OUT_WIDTH-1:0]  slices_s [RATIO];

   // Handshake decode and pop decision; the pop never looks at itself.
   always_comb begin
      busy_s      = (state_q == S_UNPACK);
      fire_s      = busy_s & out_ready;
      last_fire_s = fire_s & (idx_q == IDX_LAST);
      pop_s       = ~rst & ~fifo_empty & (~busy_s | last_fire_s);
   end

   // Next-state logic: load on pop, advance on fire, go idle after the last slice.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) begin
               state_d = S_UNPACK;
               hold_d  = data_in;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UNPACK: begin
            if (pop_s) begin
               // back-to-back: last slice accepted and a new word is waiting
               state_d = S_UNPACK;
               hold_d  = data_in;
               idx_d   = '0;
            end else if (last_fire_s) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (fire_s) begin
               idx_d   = idx_q + IDX_ONE;
            end else begin
               state_d = S_UNPACK;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State, hold word and slice index; asynchronous reset discards a partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
      end
   end

   // Split the hold word into slices and pick the one for the current index.
   always_comb begin
      for (int k = 0; k < RATIO; k++) begin
         slices_s[k] = hold_q[k*OUT_WIDTH +: OUT_WIDTH];
      end
      if (LSB_FIRST) begin
         sel_s = idx_q;
      end else begin
         sel_s = IDX_LAST - idx_q;
      end
   end

   // Output drive: everything comes straight from registered state except the pop strobe.
   always_comb begin
      out_valid = busy_s;
      out_last  = busy_s & (idx_q == IDX_LAST);
      out_data  = slices_s[sel_s];
      r_ready   = pop_s;
   end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: one instance per slice order sharing the same
// FIFO stimulus, a remaining-slice model, and literal stream checks.
module tb_fifo_unpacker;

   localparam int IW = 64;
   localparam int OW = 16;
   localparam int R  = IW / OW;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty;
   logic [IW-1:0] data_in;
   logic          out_ready;

   logic          r_ready0, out_valid0, out_last0;
   logic [OW-1:0] out_data0;
   logic          r_ready1, out_valid1, out_last1;
   logic [OW-1:0] out_data1;

   fifo_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .data_in(data_in),
      .r_ready(r_ready0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_last(out_last0)
   );

   fifo_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .data_in(data_in),
      .r_ready(r_ready1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_last(out_last1)
   );

   always #5 clk = ~clk;

   // FIFO contents and model state
   logic [IW-1:0] fifo_q [$];
   logic [IW-1:0] m_word = '0;
   int            m_rem  = 0;
   bit            m_clr  = 1'b1;

   // Observation logs for literal checks
   int            cyc = 0;
   int            rr_log [$];
   int            v_log  [$];
   logic [OW-1:0] s0_log [$];
   logic [OW-1:0] s1_log [$];
   bit            l0_log [$];
   bit            l1_log [$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [OW-1:0] slice_of(input logic [IW-1:0] w, input int pos, input bit lsb);
      int p;
      p = lsb ? pos : (R - 1 - pos);
      return w[p*OW +: OW];
   endfunction

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      data_in    = fifo_empty ? 64'h0 : fifo_q[0];
   endtask

   task automatic clear_logs();
      rr_log.delete(); v_log.delete();
      s0_log.delete(); s1_log.delete();
      l0_log.delete(); l1_log.delete();
   endtask

   // One clock: compare on the falling edge, advance model after the rising edge.
   task automatic cycle();
      bit ev, el, er, fire_n, pop_n;
      @(negedge clk);
      ev = !rst && (m_rem > 0);
      el = !rst && (m_rem == 1);
      er = !rst && (fifo_q.size() > 0) && ((m_rem == 0) || ((m_rem == 1) && out_ready));
      chk("valid_lsb", out_valid0, ev);
      chk("valid_msb", out_valid1, ev);
      chk("last_lsb",  out_last0,  el);
      chk("last_msb",  out_last1,  el);
      chk("rready_lsb", r_ready0,  er);
      chk("rready_msb", r_ready1,  er);
      if (ev) begin
         chk("data_lsb", out_data0, slice_of(m_word, R - m_rem, 1'b1));
         chk("data_msb", out_data1, slice_of(m_word, R - m_rem, 1'b0));
      end else if (rst || m_clr) begin
         chk("data_lsb_zero", out_data0, 64'h0);
         chk("data_msb_zero", out_data1, 64'h0);
      end
      if (r_ready0)  rr_log.push_back(cyc);
      if (out_valid0) v_log.push_back(cyc);
      if (out_valid0 && out_ready) begin
         s0_log.push_back(out_data0); l0_log.push_back(out_last0);
      end
      if (out_valid1 && out_ready) begin
         s1_log.push_back(out_data1); l1_log.push_back(out_last1);
      end
      fire_n = ev && out_ready;
      pop_n  = er;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         m_rem  = 0;
         m_word = '0;
         m_clr  = 1'b1;
         fifo_q.delete();
      end else begin
         if (fire_n) m_rem--;
         if (pop_n) begin
            m_word = fifo_q.pop_front();
            m_rem  = R;
            m_clr  = 1'b0;
         end
      end
      drive_fifo();
   endtask

   logic [OW-1:0] exp_up   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
   logic [OW-1:0] exp_down [4] = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
   logic [OW-1:0] exp_rst  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

   initial begin
      int pushed;
      int budget;
      rst       = 1'b0;
      out_ready = 1'b0;
      drive_fifo();
      #2 rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;

      // Empty FIFO after reset: nothing popped, nothing valid.
      clear_logs();
      repeat (10) cycle();
      chk("idle_pops",  rr_log.size(), 0);
      chk("idle_valid", v_log.size(),  0);

      // Single word, both slice orders.
      clear_logs();
      out_ready = 1'b1;
      fifo_q.push_back(64'h0004_0003_0002_0001);
      drive_fifo();
      repeat (8) cycle();
      chk("single_pops", rr_log.size(), 1);
      chk("single_nvalid", v_log.size(), 4);
      if (rr_log.size() == 1 && v_log.size() == 4) begin
         chk("single_latency", v_log[0] - rr_log[0], 1);
         chk("single_contig", v_log[3] - v_log[0], 3);
      end
      chk("single_ns_lsb", s0_log.size(), 4);
      chk("single_ns_msb", s1_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < s0_log.size()) begin
            chk($sformatf("lsb_slice%0d", i), s0_log[i], exp_up[i]);
            chk($sformatf("lsb_last%0d", i),  l0_log[i], (i == 3) ? 1 : 0);
         end
         if (i < s1_log.size()) begin
            chk($sformatf("msb_slice%0d", i), s1_log[i], exp_down[i]);
            chk($sformatf("msb_last%0d", i),  l1_log[i], (i == 3) ? 1 : 0);
         end
      end

      // Three back-to-back words.
      clear_logs();
      for (int i = 1; i <= 3; i++) fifo_q.push_back(64'(i) * 64'h0001_0001_0001_0001);
      drive_fifo();
      repeat (16) cycle();
      chk("b2b_nvalid", v_log.size(), 12);
      chk("b2b_pops",   rr_log.size(), 3);
      if (v_log.size() == 12 && rr_log.size() == 3) begin
         chk("b2b_contig", v_log[11] - v_log[0], 11);
         chk("b2b_gap1",   rr_log[1] - rr_log[0], 4);
         chk("b2b_gap2",   rr_log[2] - rr_log[1], 4);
         chk("b2b_lastfire1", rr_log[1], v_log[3]);
         chk("b2b_lastfire2", rr_log[2], v_log[7]);
      end
      if (s0_log.size() == 12) begin
         chk("b2b_w2_s0", s0_log[4],  16'h0002);
         chk("b2b_w3_s3", s0_log[11], 16'h0003);
      end

      // Reset after the second slice of a word.
      clear_logs();
      fifo_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
      drive_fifo();
      repeat (3) cycle();
      chk("pre_rst_slices", s0_log.size(), 2);
      rst = 1'b1;
      #1;
      chk("rst_valid", out_valid0, 0);
      chk("rst_data",  out_data0,  64'h0);
      chk("rst_last",  out_last0,  0);
      chk("rst_rready", r_ready0,  0);
      cycle();
      rst = 1'b0;
      clear_logs();
      fifo_q.push_back(64'h4444_3333_2222_1111);
      drive_fifo();
      repeat (6) cycle();
      chk("post_rst_ns", s0_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < s0_log.size()) chk($sformatf("post_rst_slice%0d", i), s0_log[i], exp_rst[i]);
      end

      // Random backpressure with a 200-word random fill.
      clear_logs();
      pushed = 0;
      budget = 0;
      while ((pushed < 200 || fifo_q.size() > 0 || m_rem > 0) && budget < 6000) begin
         if (pushed < 200 && fifo_q.size() < 8 && $urandom_range(0, 2) != 0) begin
            fifo_q.push_back({$urandom, $urandom});
            pushed++;
         end
         drive_fifo();
         out_ready = ($urandom_range(0, 1) == 1);
         cycle();
         budget++;
      end
      chk("rand_timeout", budget < 6000, 1);
      chk("rand_slices_lsb", s0_log.size(), 200 * R);
      chk("rand_slices_msb", s1_log.size(), 200 * R);
      chk("rand_pops", rr_log.size(), 200);
      out_ready = 1'b1;
      repeat (3) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
